// File: rtl/multi_pwm.sv
// multi_pwm: multi-channel PWM generator.
// One shared period counter, driven by a programmable prescaler, feeds
// CHANNELS duty comparators. Each channel has its own polarity. The counter
// runs edge-aligned (sawtooth) or center-aligned (triangle). Duty, polarity,
// mode and prescale are held in shadow registers. The shadows reload only at
// a period boundary, so mid-period writes never produce runt pulses.
module multi_pwm #(
    parameter int WIDTH    = 10,
    parameter int CHANNELS = 4,
    parameter int PRESC_W  = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_en,
    input  logic                      i_mode,
    input  logic [PRESC_W-1:0]        i_presc,
    input  logic [CHANNELS*WIDTH-1:0] i_dc,
    input  logic [CHANNELS-1:0]       i_pol,
    output logic [CHANNELS-1:0]       o_pwm,
    output logic                      o_period_start
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [WIDTH-1:0]   CNT_MAX   = '1;
    localparam logic [WIDTH-1:0]   CNT_ONE   = WIDTH'(1);
    localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

    logic [PRESC_W-1:0]        presc_cnt_reg;
    logic [WIDTH-1:0]          cnt_reg;
    dir_t                      dir_reg;

    logic [CHANNELS*WIDTH-1:0] dc_sh_reg;
    logic [CHANNELS-1:0]       pol_sh_reg;
    logic                      mode_sh_reg;
    logic [PRESC_W-1:0]        presc_sh_reg;

    logic [CHANNELS-1:0]       pwm_reg;
    logic [CHANNELS-1:0]       pwm_next;
    logic                      period_start_reg;
    logic                      period_start_next;

    logic                      tick;
    logic                      period_end;
    logic                      boundary;
    logic [CHANNELS-1:0]       active;

    // A counter step happens when the prescaler reaches its shadowed limit.
    assign tick = (presc_cnt_reg == presc_sh_reg);

    // Edge mode ends a period at the top of the ramp. Center mode ends it at
    // 1 on the way down, so that the next period restarts cleanly from 0.
    assign period_end = tick && (mode_sh_reg ? (dir_reg == DIR_DOWN && cnt_reg == CNT_ONE)
                                             : (cnt_reg == CNT_MAX));

    // While disabled, every clock acts as a boundary. The counters stay
    // parked at 0, and the shadows follow the live inputs.
    assign boundary = period_end || !i_en;

    // Prescaler, period counter and count direction.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc_cnt_reg <= '0;
            cnt_reg       <= '0;
            dir_reg       <= DIR_UP;
        end else if (boundary) begin
            presc_cnt_reg <= '0;
            cnt_reg       <= '0;
            dir_reg       <= DIR_UP;
        end else if (tick) begin
            presc_cnt_reg <= '0;
            if (!mode_sh_reg || dir_reg == DIR_UP) begin
                if (mode_sh_reg && cnt_reg == CNT_MAX) begin
                    // Top of the triangle: turn around without repeating MAX.
                    dir_reg <= DIR_DOWN;
                    cnt_reg <= CNT_MAX - CNT_ONE;
                end else begin
                    cnt_reg <= cnt_reg + CNT_ONE;
                end
            end else begin
                cnt_reg <= cnt_reg - CNT_ONE;
            end
        end else begin
            presc_cnt_reg <= presc_cnt_reg + PRESC_ONE;
        end
    end

    // Shadow settings load from the live inputs only on a period boundary.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dc_sh_reg    <= '0;
            pol_sh_reg   <= '0;
            mode_sh_reg  <= 1'b0;
            presc_sh_reg <= '0;
        end else if (boundary) begin
            dc_sh_reg    <= i_dc;
            pol_sh_reg   <= i_pol;
            mode_sh_reg  <= i_mode;
            presc_sh_reg <= i_presc;
        end
    end

    // Per-channel duty compare. The polarity bit sets the inactive level.
    // When disabled, each channel holds its inactive level.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign active[gi]   = (cnt_reg < dc_sh_reg[gi*WIDTH +: WIDTH]);
            assign pwm_next[gi] = pol_sh_reg[gi] ^ (i_en & active[gi]);
        end
    endgenerate

    // The period-start marker coincides with the first output sample of a
    // period. Because it requires prescaler phase 0, it fires once per period.
    assign period_start_next = i_en && (cnt_reg == '0) && (presc_cnt_reg == '0)
                               && (dir_reg == DIR_UP);

    // Registered outputs, one clock behind the counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pwm_reg          <= '0;
            period_start_reg <= 1'b0;
        end else begin
            pwm_reg          <= pwm_next;
            period_start_reg <= period_start_next;
        end
    end

    assign o_pwm          = pwm_reg;
    assign o_period_start = period_start_reg;

endmodule

// File: doc/multi_pwm.md
Name: multi_pwm

Overview:
- Parametrised multi-channel PWM generator; successor to the single-channel 10-bit edge-aligned PWM.
- One shared period counter with a programmable prescaler drives CHANNELS independent duty comparators.
- Adds per-channel polarity, a center-aligned mode, and glitch-free shadow loading of all settings at period boundaries.
- Sits between board switches/register logic and GPIO pins.

Parameters:
- WIDTH, 10, counter/duty width; edge-mode period is 2^WIDTH ticks.
- CHANNELS, 4, number of PWM outputs.
- PRESC_W, 8, prescaler setting width.

Ports:
- i_clk  input  1  system clock (50 MHz board clock).
- i_rst_n  input  1  asynchronous active-low reset.
- i_en  input  1  global enable, live (not shadowed).
- i_mode  input  1  0 = edge-aligned, 1 = center-aligned; shadowed.
- i_presc  input  PRESC_W  tick every i_presc+1 clocks; shadowed.
- i_dc  input  CHANNELS*WIDTH  duty per channel, channel k at bits [k*WIDTH +: WIDTH]; shadowed.
- i_pol  input  CHANNELS  per-channel polarity (1 = inverted output); shadowed.
- o_pwm  output  CHANNELS  PWM outputs, registered.
- o_period_start  output  1  one-clock pulse aligned with the first output sample of each period.

Behaviour:
- Reset (async, i_rst_n=0): all registers clear. This includes the prescaler count, period count, direction (up), shadows (dc=0, pol=0, mode=0, presc=0), o_pwm=0 and o_period_start=0. Assertion mid-operation takes effect immediately without waiting for a clock edge.
- Prescaler: presc_cnt counts 0..presc_sh. A tick occurs on the clock where presc_cnt==presc_sh, and presc_cnt then returns to 0. With presc_sh=0, every clock is a tick.
- Edge mode: cnt increments on each tick over 0..2^WIDTH-1. Period end is a tick at cnt==MAX.
- Center mode: cnt counts up 0..MAX, then down MAX-1..1, then returns to 0. The direction flips on the tick at cnt==MAX. Period end is a tick at cnt==1 while counting down. The period is 2*MAX ticks.
- Period boundary = period-end tick, or any clock with i_en=0. On a boundary:
  - cnt <= 0, dir <= up, presc_cnt <= 0.
  - All shadows load from the live inputs on the same edge.
- Disabled (i_en=0):
  - Counters are held at 0 and shadows track the inputs every clock.
  - o_pwm <= pol_sh (inactive level); o_period_start <= 0.
  - On the first enabled clock, a period starts at cnt=0 with the settings captured on the last disabled clock.
- Compare, per channel k: active_k = (cnt < dc_sh[k]), an unsigned WIDTH-bit compare.
  - o_pwm[k] <= pol_sh[k] ^ (i_en & active_k).
  - Latency is one clock from the counter value to the output.
- dc=0 gives the output permanently inactive. dc=MAX in edge mode gives the output active for MAX of 2^WIDTH ticks; 100 % duty is not reachable, by design.
- o_period_start <= i_en & (cnt==0) & (presc_cnt==0) & dir_up. Exactly one pulse per period, regardless of prescale.
- Mid-period changes to i_dc, i_pol, i_mode or i_presc have no effect until the next boundary. There are no runt pulses from mid-period updates.
- Mode switch at a boundary: the new period starts at cnt=0 counting up in the new mode.
- Reset during a period: outputs go low asynchronously. After release, the block behaves as from power-up. o_pwm=0 with pol_sh=0 is the inactive level.

Test Plan:
- Edge, WIDTH=10, presc=0, dc0=256, pol=0, en=1 -> o_pwm[0] high 256 clocks, low 768, period 1024. o_period_start pulses every 1024 clocks, coincident with the rising edge.
- Center, dc0=256, presc=0 -> period 2046 clocks. Per period, o_pwm[0] is high 256 clocks (up phase) plus 255 clocks (down phase), contiguous across the boundary. dc1=0 gives constant 0. dc2=1023 gives high for all but 1023..1023 (2045 high).
- Edge, presc=3, dc0=512 -> period 4096 clocks, high 2048. o_period_start is one clock wide.
- Shadowing: change dc0 256->700 at cnt=100 -> the current period still ends high at 256. The next period, after o_period_start, is high for 700.
- Polarity/enable: pol=4'b1010, dc=all 300 -> channels 1 and 3 are the complements of channels 0 and 2. Drop en -> the next clock gives o_pwm=4'b1010 and o_period_start=0. Re-raise en -> o_period_start on the first enabled clock +1.
- Async reset mid-period (i_rst_n low between clock edges) -> o_pwm=0 and o_period_start=0 immediately. After release with en=1, the first period starts at cnt=0.
